// File: rtl/pulse_stream_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : pulse_stream_monitor_if
// Purpose  : Valid/ready measurement record port of pulse_stream_monitor.
// Revision : 1.0
// ============================================================================
interface pulse_stream_monitor_if #(
   parameter int CNT_W = 16
);
   logic             meas_valid;
   logic             meas_ready;
   logic [CNT_W-1:0] meas_width;
   logic [CNT_W-1:0] meas_gap;
   logic             meas_first;

   modport master (
      output meas_valid,
      output meas_width,
      output meas_gap,
      output meas_first,
      input  meas_ready
   );

   modport slave (
      input  meas_valid,
      input  meas_width,
      input  meas_gap,
      input  meas_first,
      output meas_ready
   );
endinterface
`default_nettype wire

// File: rtl/pulse_stream_monitor.sv
`default_nettype none
// ============================================================================
// Module   : pulse_stream_monitor
// Purpose  : Measures high width and preceding low gap of each pulse on a
//            synchronised line, keeps gap statistics, emits valid/ready records.
// Revision : 1.0
// ============================================================================
module pulse_stream_monitor #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int MIN_WIDTH   = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   clear,
   input  logic                   pulse_in,
   pulse_stream_monitor_if.master meas,
   output logic [CNT_W-1:0]       pulse_count,
   output logic [CNT_W-1:0]       min_gap,
   output logic [CNT_W-1:0]       max_gap,
   output logic                   overrun,
   output logic                   sat
);

   localparam logic [CNT_W-1:0] c_ONES      = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] c_MIN_WIDTH = CNT_W'(MIN_WIDTH);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_LOW  = 2'd1;
   localparam logic [1:0] c_HIGH = 2'd2;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_s_d;
   logic                   w_s;
   logic                   w_rise;
   logic                   w_fall;

   logic [1:0]             r_state;
   logic [CNT_W-1:0]       r_gap_cnt;
   logic [CNT_W-1:0]       r_width_cnt;
   logic                   r_first;
   logic                   r_emit;
   logic [CNT_W-1:0]       r_emit_width;
   logic [CNT_W-1:0]       r_emit_gap;

   logic                   r_meas_valid;
   logic [CNT_W-1:0]       r_meas_width;
   logic [CNT_W-1:0]       r_meas_gap;
   logic                   r_meas_first;
   logic [CNT_W-1:0]       r_pulse_count;
   logic [CNT_W-1:0]       r_min_gap;
   logic [CNT_W-1:0]       r_max_gap;
   logic                   r_overrun;
   logic                   r_sat;

   logic                   w_good;
   logic [CNT_W:0]         w_glitch_sum;
   logic                   w_sat_hit;
   logic                   w_enter_low;
   logic                   w_first_eff;
   logic                   w_out_free;
   logic [CNT_W-1:0]       w_cnt_base;
   logic [CNT_W-1:0]       w_min_base;
   logic [CNT_W-1:0]       w_max_base;

   function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
      return (v == c_ONES) ? v : v + c_ONE;
   endfunction

   assign w_s    = r_sync[SYNC_STAGES-1];
   assign w_rise = w_s & ~r_s_d;
   assign w_fall = ~w_s & r_s_d;

   assign w_good       = (r_width_cnt >= c_MIN_WIDTH);
   // A glitch folds its high time plus the current low cycle back into the gap
   assign w_glitch_sum = {1'b0, r_gap_cnt} + {1'b0, r_width_cnt} + {{CNT_W{1'b0}}, 1'b1};
   assign w_enter_low  = en && (r_state == c_IDLE) && !w_s;

   assign w_sat_hit = en && (
         ((r_state == c_LOW)  && !w_rise && (r_gap_cnt == c_ONES))
      || ((r_state == c_HIGH) && !w_fall && (r_width_cnt == c_ONES))
      || ((r_state == c_HIGH) &&  w_fall && !w_good && w_glitch_sum[CNT_W]));

   // Gap counting starts at 1 on the fall edge: that cycle is already low
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync       <= '0;
         r_s_d        <= 1'b0;
         r_state      <= c_IDLE;
         r_gap_cnt    <= '0;
         r_width_cnt  <= '0;
         r_emit       <= 1'b0;
         r_emit_width <= '0;
         r_emit_gap   <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], pulse_in};
         r_s_d  <= w_s;
         r_emit <= 1'b0;
         if (!en) begin
            r_state <= c_IDLE;
         end else begin
            case (r_state)
               c_IDLE: begin
                  if (!w_s) begin
                     r_state   <= c_LOW;
                     r_gap_cnt <= '0;
                  end
               end
               c_LOW: begin
                  if (w_rise) begin
                     r_state     <= c_HIGH;
                     r_width_cnt <= c_ONE;
                  end else begin
                     r_gap_cnt <= f_sat_inc(r_gap_cnt);
                  end
               end
               c_HIGH: begin
                  if (w_fall) begin
                     r_state <= c_LOW;
                     if (w_good) begin
                        r_emit       <= 1'b1;
                        r_emit_width <= r_width_cnt;
                        r_emit_gap   <= r_gap_cnt;
                        r_gap_cnt    <= c_ONE;
                     end else begin
                        r_gap_cnt <= w_glitch_sum[CNT_W] ? c_ONES : w_glitch_sum[CNT_W-1:0];
                     end
                  end else begin
                     r_width_cnt <= f_sat_inc(r_width_cnt);
                  end
               end
               default: r_state <= c_IDLE;
            endcase
         end
      end
   end

   // clear takes effect before a coincident emit, so the emit sees cleared bases
   assign w_first_eff = r_first | clear;
   assign w_out_free  = ~r_meas_valid | meas.meas_ready;
   assign w_cnt_base  = clear ? '0     : r_pulse_count;
   assign w_min_base  = clear ? c_ONES : r_min_gap;
   assign w_max_base  = clear ? '0     : r_max_gap;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_first       <= 1'b1;
         r_meas_valid  <= 1'b0;
         r_meas_width  <= '0;
         r_meas_gap    <= '0;
         r_meas_first  <= 1'b0;
         r_pulse_count <= '0;
         r_min_gap     <= c_ONES;
         r_max_gap     <= '0;
         r_overrun     <= 1'b0;
         r_sat         <= 1'b0;
      end else begin
         r_pulse_count <= r_emit ? f_sat_inc(w_cnt_base) : w_cnt_base;
         r_min_gap     <= (r_emit && !w_first_eff && (r_emit_gap < w_min_base)) ? r_emit_gap : w_min_base;
         r_max_gap     <= (r_emit && !w_first_eff && (r_emit_gap > w_max_base)) ? r_emit_gap : w_max_base;
         r_overrun     <= (r_overrun && !clear) || (r_emit && !w_out_free);
         r_sat         <= (r_sat && !clear) || w_sat_hit;

         if (r_emit) begin
            r_first <= 1'b0;
         end else if (clear || w_enter_low) begin
            r_first <= 1'b1;
         end

         if (r_emit && w_out_free) begin
            r_meas_valid <= 1'b1;
            r_meas_width <= r_emit_width;
            r_meas_gap   <= w_first_eff ? '0 : r_emit_gap;
            r_meas_first <= w_first_eff;
         end else if (r_meas_valid && meas.meas_ready) begin
            r_meas_valid <= 1'b0;
         end
      end
   end

   assign meas.meas_valid = r_meas_valid;
   assign meas.meas_width = r_meas_width;
   assign meas.meas_gap   = r_meas_gap;
   assign meas.meas_first = r_meas_first;
   assign pulse_count     = r_pulse_count;
   assign min_gap         = r_min_gap;
   assign max_gap         = r_max_gap;
   assign overrun         = r_overrun;
   assign sat             = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_pulse_stream_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pulse_stream_monitor
// Purpose  : Self-checking bench for pulse_stream_monitor (two configurations).
// Revision : 1.0
// ============================================================================
module tb_pulse_stream_monitor;

   typedef struct { int w; int g; bit f; } rec_t;
   typedef struct { int hi; int lo; int exp_gap; bit exp_first; } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        en0, clear0, pin0;
   logic        en1, clear1, pin1;
   logic [15:0] cnt0, min0, max0;
   logic        ovr0, sat0;
   logic [3:0]  cnt1, min1, max1;
   logic        ovr1, sat1;

   int   n_cmp  = 0;
   int   n_fail = 0;
   rec_t q0[$];
   rec_t q1[$];

   always #5 clk = ~clk;

   pulse_stream_monitor_if #(.CNT_W(16)) if0 ();
   pulse_stream_monitor_if #(.CNT_W(4))  if1 ();

   pulse_stream_monitor #(.CNT_W(16), .SYNC_STAGES(2), .MIN_WIDTH(1)) u_dut0 (
      .clk(clk), .rst(rst), .en(en0), .clear(clear0), .pulse_in(pin0),
      .meas(if0.master), .pulse_count(cnt0), .min_gap(min0), .max_gap(max0),
      .overrun(ovr0), .sat(sat0));

   pulse_stream_monitor #(.CNT_W(4), .SYNC_STAGES(2), .MIN_WIDTH(3)) u_dut1 (
      .clk(clk), .rst(rst), .en(en1), .clear(clear1), .pulse_in(pin1),
      .meas(if1.master), .pulse_count(cnt1), .min_gap(min1), .max_gap(max1),
      .overrun(ovr1), .sat(sat1));

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input int sel, input int hi, input int lo, output int lat);
      if (sel == 0) pin0 = 1'b1; else pin1 = 1'b1;
      cyc(hi);
      if (sel == 0) pin0 = 1'b0; else pin1 = 1'b0;
      lat = -1;
      for (int k = 1; k <= lo; k++) begin
         @(posedge clk);
         #1;
         if (lat < 0 && ((sel == 0) ? if0.meas_valid : if1.meas_valid)) lat = k;
      end
   endtask

   always @(negedge clk) begin : mon0
      rec_t e;
      if (!rst && if0.meas_valid && if0.meas_ready) begin
         if (q0.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rec0_extra: got width %0d gap %0d, want no record", if0.meas_width, if0.meas_gap);
         end else begin
            e = q0.pop_front();
            chk("rec0_width", if0.meas_width, e.w);
            chk("rec0_gap",   if0.meas_gap,   e.g);
            chk("rec0_first", if0.meas_first, e.f);
         end
      end
   end

   always @(negedge clk) begin : mon1
      rec_t e;
      if (!rst && if1.meas_valid && if1.meas_ready) begin
         if (q1.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rec1_extra: got width %0d gap %0d, want no record", if1.meas_width, if1.meas_gap);
         end else begin
            e = q1.pop_front();
            chk("rec1_width", if1.meas_width, e.w);
            chk("rec1_gap",   if1.meas_gap,   e.g);
            chk("rec1_first", if1.meas_first, e.f);
         end
      end
   end

   initial begin
      vec_t tbl[5];
      int   lat;
      int   exp_cnt, exp_min, exp_max;

      tbl[0] = '{hi:5, lo:7,  exp_gap:0,  exp_first:1'b1};
      tbl[1] = '{hi:3, lo:9,  exp_gap:7,  exp_first:1'b0};
      tbl[2] = '{hi:2, lo:6,  exp_gap:9,  exp_first:1'b0};
      tbl[3] = '{hi:6, lo:12, exp_gap:6,  exp_first:1'b0};
      tbl[4] = '{hi:1, lo:5,  exp_gap:12, exp_first:1'b0};

      rst = 1'b1;
      en0 = 1'b0; clear0 = 1'b0; pin0 = 1'b0;
      en1 = 1'b0; clear1 = 1'b0; pin1 = 1'b0;
      if0.meas_ready = 1'b1;
      if1.meas_ready = 1'b1;
      cyc(3);
      rst = 1'b0;

      chk("rst_valid", if0.meas_valid, 0);
      chk("rst_width", if0.meas_width, 0);
      chk("rst_gap",   if0.meas_gap,   0);
      chk("rst_first", if0.meas_first, 0);
      chk("rst_count", cnt0, 0);
      chk("rst_min",   min0, 16'hFFFF);
      chk("rst_max",   max0, 0);
      chk("rst_ovr",   ovr0, 0);
      chk("rst_sat",   sat0, 0);

      // Table-driven pulse train on the default configuration
      en0 = 1'b1;
      cyc(4);
      exp_cnt = 0;
      exp_min = 16'hFFFF;
      exp_max = 0;
      for (int i = 0; i < 5; i++) begin
         q0.push_back('{w:tbl[i].hi, g:tbl[i].exp_gap, f:tbl[i].exp_first});
         drive(0, tbl[i].hi, tbl[i].lo, lat);
         exp_cnt++;
         if (!tbl[i].exp_first) begin
            if (tbl[i].exp_gap < exp_min) exp_min = tbl[i].exp_gap;
            if (tbl[i].exp_gap > exp_max) exp_max = tbl[i].exp_gap;
         end
         chk($sformatf("latency_%0d", i), lat, 4);
         chk($sformatf("count_%0d", i), cnt0, exp_cnt);
         chk($sformatf("min_%0d", i), min0, exp_min);
         chk($sformatf("max_%0d", i), max0, exp_max);
      end

      // Overrun: consumer stalled over three pulses
      clear0 = 1'b1;
      cyc(1);
      clear0 = 1'b0;
      chk("clr_count", cnt0, 0);
      chk("clr_min",   min0, 16'hFFFF);
      if0.meas_ready = 1'b0;
      q0.push_back('{w:3, g:0, f:1'b1});
      for (int i = 0; i < 3; i++) drive(0, 3, 6, lat);
      chk("ovr_valid", if0.meas_valid, 1);
      chk("ovr_width", if0.meas_width, 3);
      chk("ovr_first", if0.meas_first, 1);
      chk("ovr_flag",  ovr0, 1);
      chk("ovr_count", cnt0, 3);
      chk("ovr_min",   min0, 6);
      chk("ovr_max",   max0, 6);
      if0.meas_ready = 1'b1;
      cyc(1);
      chk("ovr_drain", if0.meas_valid, 0);
      q0.push_back('{w:3, g:7, f:1'b0});
      drive(0, 3, 6, lat);
      chk("ovr_sticky", ovr0, 1);

      // clear lands on the emit edge of the next record
      q0.push_back('{w:4, g:0, f:1'b1});
      pin0 = 1'b1;
      cyc(4);
      pin0 = 1'b0;
      cyc(3);
      clear0 = 1'b1;
      cyc(1);
      clear0 = 1'b0;
      cyc(4);
      chk("ce_count", cnt0, 1);
      chk("ce_ovr",   ovr0, 0);
      chk("ce_min",   min0, 16'hFFFF);
      chk("ce_max",   max0, 0);

      // en dropped for one cycle while the pulse is two cycles wide
      pin0 = 1'b1;
      cyc(4);
      en0 = 1'b0;
      cyc(1);
      en0 = 1'b1;
      cyc(4);
      pin0 = 1'b0;
      cyc(8);
      chk("endrop_count", cnt0, 1);
      chk("endrop_valid", if0.meas_valid, 0);
      q0.push_back('{w:3, g:0, f:1'b1});
      drive(0, 3, 8, lat);
      chk("endrop_lat",   lat, 4);
      chk("endrop_next",  cnt0, 2);

      // Narrow configuration: glitch rejection then saturation
      en1 = 1'b1;
      cyc(4);
      q1.push_back('{w:4, g:0, f:1'b1});
      drive(1, 4, 4, lat);
      drive(1, 1, 4, lat);
      q1.push_back('{w:4, g:9, f:1'b0});
      drive(1, 4, 6, lat);
      chk("gl_count", cnt1, 2);
      chk("gl_min",   min1, 9);
      chk("gl_max",   max1, 9);
      chk("gl_sat",   sat1, 0);

      clear1 = 1'b1;
      cyc(1);
      clear1 = 1'b0;
      chk("sat_clr", sat1, 0);
      q1.push_back('{w:15, g:0, f:1'b1});
      drive(1, 18, 20, lat);
      chk("sat_width", sat1, 1);
      q1.push_back('{w:4, g:15, f:1'b0});
      drive(1, 4, 6, lat);
      chk("sat_min",   min1, 15);
      chk("sat_max",   max1, 15);
      chk("sat_count", cnt1, 2);
      chk("sat_ovr",   ovr1, 0);

      // rst with a record pending
      if0.meas_ready = 1'b0;
      drive(0, 3, 8, lat);
      chk("prerst_valid", if0.meas_valid, 1);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("mrst_valid", if0.meas_valid, 0);
      chk("mrst_width", if0.meas_width, 0);
      chk("mrst_gap",   if0.meas_gap,   0);
      chk("mrst_first", if0.meas_first, 0);
      chk("mrst_count", cnt0, 0);
      chk("mrst_min",   min0, 16'hFFFF);
      chk("mrst_max",   max0, 0);
      chk("mrst_ovr",   ovr0, 0);
      chk("mrst_sat",   sat0, 0);
      chk("mrst_count1", cnt1, 0);

      chk("q0_left", q0.size(), 0);
      chk("q1_left", q1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pulse_stream_monitor.md
Name: pulse_stream_monitor

Overview:
Receive-side companion to the random pulse generator. Samples a single pulse line, filters glitches, measures each pulse's high width and the low gap before it, and keeps running statistics (count, min/max gap). Each measured pulse is presented as a record on a valid/ready output port, for a host-side readout or logging stage.

Parameters:
CNT_W, 16, width of width/gap/count counters and outputs
SYNC_STAGES, 2, flops in the pulse_in synchronizer (min 2)
MIN_WIDTH, 1, shortest high time in cycles accepted as a pulse; shorter highs are glitches

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous active-high reset
en  in  1  monitor enable
clear  in  1  one-cycle pulse that clears statistics and sticky flags
pulse_in  in  1  pulse line under test (may be asynchronous)
meas_valid  out  1  record available
meas_ready  in  1  consumer accepts record
meas_width  out  CNT_W  high time of the pulse in cycles
meas_gap  out  CNT_W  low time before the pulse in cycles (0 for first pulse)
meas_first  out  1  record is the first pulse since en rose, rst or clear
pulse_count  out  CNT_W  accepted pulses, saturating
min_gap  out  CNT_W  smallest gap seen (all-ones until first non-first record)
max_gap  out  CNT_W  largest gap seen (0 until first non-first record)
overrun  out  1  sticky: record dropped because meas_valid was high and meas_ready low
sat  out  1  sticky: a width or gap counter saturated

Behaviour:
- Reset (rst=1 at a clk edge) sets: all sync flops=0, FSM=IDLE, meas_valid=0, meas_width=0, meas_gap=0, meas_first=0, pulse_count=0, min_gap=all-ones, max_gap=0, overrun=0, sat=0. rst overrides every other input.
- Synchronizer: s = last stage of SYNC_STAGES flops. s_d = s delayed 1 cycle. rise = s & ~s_d. fall = ~s & s_d.
- FSM states:
  - IDLE: waits for en=1 and s=0, then goes to LOW with first=1 and gap_cnt=0. A line already high at enable is ignored until it falls.
  - LOW: gap_cnt increments each cycle. On rise, go to HIGH with width_cnt=1.
  - HIGH: width_cnt increments each cycle s=1. On fall:
    - width_cnt >= MIN_WIDTH: emit record, clear gap_cnt, first=0, go to LOW.
    - Otherwise it is a glitch: no record; gap_cnt adds width_cnt (saturating), go to LOW.
- Counters saturate at all-ones and set sat. They never wrap.
- Record emit happens on the edge after fall is detected:
  - meas_width = width_cnt.
  - meas_gap = 0 if first, else gap_cnt.
  - meas_first = first.
  - pulse_count += 1 (saturating).
  - If not first: min_gap = min(min_gap, gap), max_gap = max(max_gap, gap).
- End-to-end latency: pulse_in falling to meas_valid high is SYNC_STAGES+2 cycles.
- Handshake:
  - meas_valid stays high and record fields stay stable until a cycle with meas_valid & meas_ready.
  - Emit while output is empty, or in the same cycle as an accept: load the new record, meas_valid=1.
  - Emit while meas_valid=1 and meas_ready=0: new record dropped, overrun=1. pulse_count and min/max still update.
- en=0: FSM returns to IDLE at the next edge; the partial pulse is discarded. Statistics and any pending record are held, and the handshake keeps working.
- clear: pulse_count=0, min_gap=all-ones, max_gap=0, overrun=0, sat=0, first=1. FSM and the pending record are untouched.
  - clear in the same cycle as an emit: clear applies first, then the emit. Result: pulse_count=1, record marked first, min/max unchanged from cleared values.
- rst mid-pulse or with a pending record: everything returns to reset values and the record is lost.

Test Plan:
- rst high 3 cycles, en=1, pulse_in high 5 cycles, low 7, high 3, then low -> record 1 {width=5, gap=0, first=1}; record 2 {width=3, gap=7, first=0}; pulse_count=2, min_gap=max_gap=7; meas_valid rises 4 cycles after each falling edge (SYNC_STAGES=2).
- MIN_WIDTH=3; pulses low 4, high 1 (glitch), low 4, high 4 -> one non-first record with gap=9, width=4; glitch produces no record.
- meas_ready=0, three pulses -> first record held stable, overrun=1, pulse_count=3; then meas_ready=1 -> one accept, meas_valid=0.
- CNT_W=4, low gap of 20 cycles between pulses -> meas_gap=15, sat=1; pulse high 18 -> meas_width=15.
- en dropped mid-pulse at width 2 for 1 cycle, then re-raised -> no record for that pulse; pulse_count unchanged; next full pulse is marked meas_first=1.
- clear asserted in the same cycle as an emit -> pulse_count=1, overrun=0, min_gap=all-ones; rst asserted while meas_valid=1 -> all outputs at reset values on the next cycle.
